// File: rtl/rd_sync_pkg.sv
// Shared definitions for the multi-channel readout synchronizer/filter.
package rd_sync_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } filt_state_e;

  localparam int RD_SYNC_STAGES_DEF = 3;
  localparam int RD_FILTER_LEN_DEF  = 4;

  // Qualification counter must hold values up to FILTER_LEN.
  function automatic int filt_cnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/rd_sync_filter_if.sv
// Bus bundle for rd_sync_filter; CNT_CLR/EVCNT exist only with RD_SYNC_EVCNT_EN.
interface rd_sync_filter_if #(
  parameter int NCH = 8
`ifdef RD_SYNC_EVCNT_EN
  , parameter int CNT_WIDTH = 16
`endif
);

  logic [NCH-1:0] ASYNC_IN;
  logic [NCH-1:0] SYNC_OUT;
  logic [NCH-1:0] RISE;
  logic [NCH-1:0] FALL;

`ifdef RD_SYNC_EVCNT_EN
  logic                     CNT_CLR;
  logic [NCH*CNT_WIDTH-1:0] EVCNT;

  modport master (
    output ASYNC_IN,
    output CNT_CLR,
    input  SYNC_OUT,
    input  RISE,
    input  FALL,
    input  EVCNT
  );

  modport slave (
    input  ASYNC_IN,
    input  CNT_CLR,
    output SYNC_OUT,
    output RISE,
    output FALL,
    output EVCNT
  );
`else
  modport master (
    output ASYNC_IN,
    input  SYNC_OUT,
    input  RISE,
    input  FALL
  );

  modport slave (
    input  ASYNC_IN,
    output SYNC_OUT,
    output RISE,
    output FALL
  );
`endif

endinterface

// File: rtl/rd_sync_chain.sv
// Single-bit metastability synchronizer: STAGES flops kept together as an
// ASYNC_REG group and never mapped into shift-register primitives.
module rd_sync_chain #(
  parameter int   STAGES    = 3,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= {STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rd_sync_filter.sv
// NCH-channel synchronizer with per-channel stability filter and rise/fall
// strobes. Optional per-channel rise counters under macro RD_SYNC_EVCNT_EN.
module rd_sync_filter
  import rd_sync_pkg::*;
#(
  parameter int             NCH         = 8,
  parameter int             SYNC_STAGES = RD_SYNC_STAGES_DEF,
  parameter int             FILTER_LEN  = RD_FILTER_LEN_DEF,
  parameter logic [NCH-1:0] RESET_VAL   = '0
`ifdef RD_SYNC_EVCNT_EN
  , parameter int           CNT_WIDTH   = 16
`endif
) (
  input  logic           CLK,
  input  logic           RSTN,
  rd_sync_filter_if.slave bus
);

  localparam int CW = filt_cnt_width(FILTER_LEN);

  logic [NCH-1:0] sync_s;
  logic [NCH-1:0] out_vec;
  logic [NCH-1:0] rise_vec;
  logic [NCH-1:0] fall_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      filt_state_e   state_q;
      logic [CW-1:0] cnt_q;
      logic          out_q;
      logic          rise_q;
      logic          fall_q;

      rd_sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_BIT (RESET_VAL[gi])
      ) u_chain (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d_i  (bus.ASYNC_IN[gi]),
        .q_o  (sync_s[gi])
      );

      // Strobes are registered alongside out_q so they line up with the new level.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
          out_q   <= RESET_VAL[gi];
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          case (state_q)
            ST_STABLE: begin
              if (sync_s[gi] != out_q) begin
                if (FILTER_LEN == 1) begin
                  out_q  <= sync_s[gi];
                  rise_q <= sync_s[gi];
                  fall_q <= ~sync_s[gi];
                end else begin
                  state_q <= ST_QUAL;
                  cnt_q   <= CW'(1);
                end
              end
            end
            ST_QUAL: begin
              if (sync_s[gi] == out_q) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
              end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                out_q   <= sync_s[gi];
                rise_q  <= sync_s[gi];
                fall_q  <= ~sync_s[gi];
                state_q <= ST_STABLE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end

      assign out_vec[gi]  = out_q;
      assign rise_vec[gi] = rise_q;
      assign fall_vec[gi] = fall_q;

`ifdef RD_SYNC_EVCNT_EN
      logic [CNT_WIDTH-1:0] evcnt_q;

      // Clear wins over a coincident strobe; saturate rather than wrap.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          evcnt_q <= '0;
        end else if (bus.CNT_CLR) begin
          evcnt_q <= '0;
        end else if (rise_q && !(&evcnt_q)) begin
          evcnt_q <= evcnt_q + 1'b1;
        end
      end

      assign bus.EVCNT[gi*CNT_WIDTH +: CNT_WIDTH] = evcnt_q;
`endif
    end
  endgenerate

  assign bus.SYNC_OUT = out_vec;
  assign bus.RISE     = rise_vec;
  assign bus.FALL     = fall_vec;

endmodule

// File: tb/tb_rd_sync_filter.sv
// Directed bench for rd_sync_filter: dut_a uses 3 sync stages / filter 4,
// dut_b uses 2 sync stages / filter 1. Counter checks need RD_SYNC_EVCNT_EN.
module tb_rd_sync_filter;

  logic clk;
  logic rstn;

  int n_checks;
  int n_pass;

`ifdef RD_SYNC_EVCNT_EN
  rd_sync_filter_if #(.NCH(8), .CNT_WIDTH(4)) bus_a ();
  rd_sync_filter_if #(.NCH(8))                bus_b ();

  rd_sync_filter #(.NCH(8), .SYNC_STAGES(3), .FILTER_LEN(4), .RESET_VAL(8'h00), .CNT_WIDTH(4)) dut_a (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus_a.slave)
  );
`else
  rd_sync_filter_if #(.NCH(8)) bus_a ();
  rd_sync_filter_if #(.NCH(8)) bus_b ();

  rd_sync_filter #(.NCH(8), .SYNC_STAGES(3), .FILTER_LEN(4), .RESET_VAL(8'h00)) dut_a (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus_a.slave)
  );
`endif

  rd_sync_filter #(.NCH(8), .SYNC_STAGES(2), .FILTER_LEN(1), .RESET_VAL(8'h00)) dut_b (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in;
    logic [7:0] sync;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] in, input logic [7:0] sync,
                         input logic [7:0] rise, input logic [7:0] fall);
    vec_t v;
    v.in = in; v.sync = sync; v.rise = rise; v.fall = fall;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %h", nm, act);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0;
    bus_a.ASYNC_IN = 8'hFF;
    bus_b.ASYNC_IN = 8'h00;
`ifdef RD_SYNC_EVCNT_EN
    bus_a.CNT_CLR = 1'b0;
    bus_b.CNT_CLR = 1'b0;
`endif

    // Release with all inputs high: level appears on the 7th edge.
    for (int i = 1; i <= 9; i++)
      add_vec(8'hFF, (i >= 7) ? 8'hFF : 8'h00, (i == 7) ? 8'hFF : 8'h00, 8'h00);
    // Channel 0 falls.
    for (int i = 1; i <= 8; i++)
      add_vec(8'hFE, (i >= 7) ? 8'hFE : 8'hFF, 8'h00, (i == 7) ? 8'h01 : 8'h00);
    // Channel 0 rises while channel 5 falls.
    for (int i = 1; i <= 8; i++)
      add_vec(8'hDF, (i >= 7) ? 8'hDF : 8'hFE, (i == 7) ? 8'h01 : 8'h00, (i == 7) ? 8'h20 : 8'h00);

    step();
    step();
    chk("reset_sync_a", bus_a.SYNC_OUT, 8'h00);
    chk("reset_strobes_a", {bus_a.RISE, bus_a.FALL}, 16'h0000);
    chk("reset_sync_b", {bus_b.SYNC_OUT, bus_b.RISE, bus_b.FALL}, 24'h0);
`ifdef RD_SYNC_EVCNT_EN
    chk("reset_evcnt", bus_a.EVCNT, 32'h0);
`endif

    rstn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      bus_a.ASYNC_IN = vecs[i].in;
      step();
      chk($sformatf("vec%0d sync/rise/fall", i),
          {bus_a.SYNC_OUT, bus_a.RISE, bus_a.FALL},
          {vecs[i].sync, vecs[i].rise, vecs[i].fall});
    end

    bus_a.ASYNC_IN = 8'h00;
    repeat (10) step();
    chk("settle_zero", bus_a.SYNC_OUT, 8'h00);

    // 3-cycle pulse on ch3 must be rejected.
    for (int i = 1; i <= 12; i++) begin
      bus_a.ASYNC_IN = (i <= 3) ? 8'h08 : 8'h00;
      step();
      chk($sformatf("glitch3 step%0d", i),
          {bus_a.SYNC_OUT[3], bus_a.RISE[3], bus_a.FALL[3]}, 3'b000);
    end

    // 4-cycle pulse on ch3 passes: RISE at step 7, FALL at step 11.
    for (int i = 1; i <= 14; i++) begin
      bus_a.ASYNC_IN = (i <= 4) ? 8'h08 : 8'h00;
      step();
      chk($sformatf("pulse4 step%0d", i),
          {bus_a.SYNC_OUT[3], bus_a.RISE[3], bus_a.FALL[3]},
          {(i >= 7 && i <= 10) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0, (i == 11) ? 1'b1 : 1'b0});
    end

    // Reset two cycles into qualification of a ch1 fall.
    bus_a.ASYNC_IN = 8'h02;
    repeat (8) step();
    chk("ch1_high", bus_a.SYNC_OUT, 8'h02);
    bus_a.ASYNC_IN = 8'h00;
    repeat (5) step();
    chk("ch1_qual_hold", bus_a.SYNC_OUT, 8'h02);
    #2;
    rstn = 1'b0;
    bus_a.ASYNC_IN = 8'h02;
    #1;
    chk("midqual_async_reset", {bus_a.SYNC_OUT, bus_a.RISE, bus_a.FALL}, 24'h0);
    step();
    step();
    chk("midqual_in_reset", {bus_a.SYNC_OUT, bus_a.RISE, bus_a.FALL}, 24'h0);
    rstn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("requal step%0d", i),
          {bus_a.SYNC_OUT, bus_a.RISE, bus_a.FALL},
          {(i >= 7) ? 8'h02 : 8'h00, (i == 7) ? 8'h02 : 8'h00, 8'h00});
    end

    // dut_b: two stages, no filtering -> 3 edges from drive to output.
    for (int i = 1; i <= 8; i++) begin
      bus_b.ASYNC_IN = (i <= 4) ? 8'h01 : 8'h00;
      step();
      chk($sformatf("lat_b step%0d", i),
          {bus_b.SYNC_OUT, bus_b.RISE, bus_b.FALL},
          {(i >= 3 && i <= 6) ? 8'h01 : 8'h00, (i == 3) ? 8'h01 : 8'h00, (i == 7) ? 8'h01 : 8'h00});
    end

`ifdef RD_SYNC_EVCNT_EN
    bus_a.ASYNC_IN = 8'h00;
    repeat (10) step();
    bus_a.CNT_CLR = 1'b1;
    step();
    bus_a.CNT_CLR = 1'b0;
    chk("evcnt_cleared", bus_a.EVCNT, 32'h0);
    for (int n = 1; n <= 17; n++) begin
      bus_a.ASYNC_IN = 8'h04;
      repeat (5) step();
      bus_a.ASYNC_IN = 8'h00;
      repeat (5) step();
      chk($sformatf("evcnt2 rise%0d", n), bus_a.EVCNT[2*4 +: 4], (n > 15) ? 4'd15 : 4'(n));
    end
    repeat (4) step();
    // Clear coincident with a ch2 RISE: that event is not counted.
    bus_a.ASYNC_IN = 8'h04;
    repeat (7) step();
    chk("evcnt_rise_seen", bus_a.RISE, 8'h04);
    bus_a.CNT_CLR = 1'b1;
    step();
    bus_a.CNT_CLR = 1'b0;
    chk("evcnt_clr_rise", bus_a.EVCNT[2*4 +: 4], 4'd0);
    repeat (3) step();
    chk("evcnt_clr_hold", bus_a.EVCNT, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
